// File: rtl/csa_accum_pkg.sv
// Shared types and sizing helpers for the carry-save accumulator with chunked resolve.
package csa_accum_pkg;

  typedef enum logic [1:0] {
    ST_ACC     = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_OUT     = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 32;
  localparam int CHUNK_DEF = 8;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  function automatic int cidx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/csa_accum_resolve_csa.sv
// Library 3:2 carry-save cell: bitwise sum and majority carry (carry not yet shifted).
module csa_accum_resolve_csa #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] cy
);

  assign sum = a ^ b ^ c;
  assign cy  = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/csa_accum_resolve.sv
// Streaming carry-save accumulator; resolves each group with a CHUNK-bit-per-cycle adder.
module csa_accum_resolve
  import csa_accum_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_dat,
  input  logic             in_last,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int CIDX_W = cidx_w(NCHUNK);

  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("csa_accum_resolve: WIDTH must be a multiple of CHUNK");
  end

  state_t            state_r, next_state_s;
  logic [WIDTH-1:0]  sum_s_r, sum_c_r, c2_s;
  logic [WIDTH-1:0]  csa_sum_s, csa_cy_s;
  logic [WIDTH-1:0]  out_dat_r, out_dat_next_s;
  logic [CIDX_W-1:0] chunk_idx_r;
  logic              cin_r, in_rdy_r, out_vld_r;
  logic              acc_fire_s, last_chunk_s, co_s;
  logic [CHUNK-1:0]  s_chunk_s, c_chunk_s, r_s;
  logic              unused_s;

  // The carry word's top bit shifts out of the modulo-2^WIDTH value.
  assign unused_s     = sum_c_r[WIDTH-1];
  assign c2_s         = {sum_c_r[WIDTH-2:0], 1'b0};
  assign acc_fire_s   = in_vld && (state_r == ST_ACC);
  assign last_chunk_s = (chunk_idx_r == CIDX_W'(NCHUNK - 1));

  assign in_rdy  = in_rdy_r;
  assign out_vld = out_vld_r;
  assign out_dat = out_dat_r;

  csa_accum_resolve_csa #(.WIDTH(WIDTH)) u_csa (
    .a   (sum_s_r),
    .b   (c2_s),
    .c   (in_dat),
    .sum (csa_sum_s),
    .cy  (csa_cy_s)
  );

  // Select the active chunk of both redundant words and merge the adder result back.
  always_comb begin
    s_chunk_s      = '0;
    c_chunk_s      = '0;
    out_dat_next_s = out_dat_r;
    for (int i = 0; i < NCHUNK; i++) begin
      s_chunk_s = s_chunk_s | ((chunk_idx_r == CIDX_W'(i)) ? sum_s_r[i*CHUNK +: CHUNK] : '0);
      c_chunk_s = c_chunk_s | ((chunk_idx_r == CIDX_W'(i)) ? c2_s[i*CHUNK +: CHUNK] : '0);
      out_dat_next_s[i*CHUNK +: CHUNK] =
        (chunk_idx_r == CIDX_W'(i)) ? r_s : out_dat_r[i*CHUNK +: CHUNK];
    end
  end

  assign {co_s, r_s} = {1'b0, s_chunk_s} + {1'b0, c_chunk_s} + {{CHUNK{1'b0}}, cin_r};

  // Next-state logic for accumulate / resolve / present.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_ACC: begin
        if (acc_fire_s && in_last) next_state_s = ST_RESOLVE;
        else                       next_state_s = ST_ACC;
      end
      ST_RESOLVE: begin
        if (last_chunk_s) next_state_s = ST_OUT;
        else              next_state_s = ST_RESOLVE;
      end
      ST_OUT: begin
        if (out_rdy) next_state_s = ST_ACC;
        else         next_state_s = ST_OUT;
      end
      default: next_state_s = ST_ACC;
    endcase
  end

  // State, handshake flags and datapath registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_r     <= ST_ACC;
      sum_s_r     <= '0;
      sum_c_r     <= '0;
      chunk_idx_r <= '0;
      cin_r       <= 1'b0;
      in_rdy_r    <= 1'b1;
      out_vld_r   <= 1'b0;
      out_dat_r   <= '0;
    end else begin
      state_r   <= next_state_s;
      in_rdy_r  <= (next_state_s == ST_ACC);
      out_vld_r <= (next_state_s == ST_OUT);
      case (state_r)
        ST_ACC: begin
          chunk_idx_r <= '0;
          cin_r       <= 1'b0;
          if (acc_fire_s) begin
            sum_s_r <= csa_sum_s;
            sum_c_r <= csa_cy_s;
          end
        end
        ST_RESOLVE: begin
          out_dat_r   <= out_dat_next_s;
          cin_r       <= co_s;
          chunk_idx_r <= chunk_idx_r + CIDX_W'(1);
        end
        ST_OUT: begin
          if (out_rdy) begin
            sum_s_r <= '0;
            sum_c_r <= '0;
          end
        end
        default: begin
          sum_s_r <= '0;
          sum_c_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csa_accum_resolve.sv
// Scoreboard bench for csa_accum_resolve: directed cases, CHUNK==WIDTH variant, random groups.
module tb_csa_accum_resolve;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        in_vld, in_rdy, in_last, out_vld, out_rdy;
  logic [31:0] in_dat, out_dat;
  logic        b_in_vld, b_in_rdy, b_in_last, b_out_vld, b_out_rdy;
  logic [31:0] b_in_dat, b_out_dat;

  int          n_cmp = 0;
  int          n_mis = 0;
  logic [31:0] sb[$];
  logic [31:0] acc_m;
  bit          tx_done;

  always #5 clk = ~clk;

  csa_accum_resolve #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .arst_n(arst_n),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_dat(in_dat), .in_last(in_last),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_dat(out_dat)
  );

  csa_accum_resolve #(.WIDTH(32), .CHUNK(32)) dut32 (
    .clk(clk), .arst_n(arst_n),
    .in_vld(b_in_vld), .in_rdy(b_in_rdy), .in_dat(b_in_dat), .in_last(b_in_last),
    .out_vld(b_out_vld), .out_rdy(b_out_rdy), .out_dat(b_out_dat)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int n = 0;
    in_vld  = 1'b1;
    in_dat  = d;
    in_last = l;
    @(negedge clk);
    while (!in_rdy && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_rdy) chk("send_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    in_vld  = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic recv(input logic [31:0] exp);
    int n = 0;
    out_rdy = 1'b1;
    @(negedge clk);
    while (!out_vld && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("recv_vld", 32'(out_vld), 32'd1);
    chk("recv_dat", out_dat, exp);
    @(posedge clk);
    #1;
    out_rdy = 1'b0;
  endtask

  // Reference model: sums accepted beats mod 2^32, compares on each output handshake.
  always @(negedge clk) begin
    if (!arst_n) begin
      acc_m = 32'd0;
      sb.delete();
    end else begin
      if (in_vld && in_rdy) begin
        acc_m = acc_m + in_dat;
        if (in_last) begin
          sb.push_back(acc_m);
          acc_m = 32'd0;
        end
      end
      if (out_vld && out_rdy) begin
        if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
        else                chk("sb_result", out_dat, sb.pop_front());
      end
    end
  end

  initial begin
    int n;
    logic [31:0] hold;
    arst_n = 1'b0; in_vld = 1'b0; in_dat = 32'd0; in_last = 1'b0; out_rdy = 1'b0;
    b_in_vld = 1'b0; b_in_dat = 32'd0; b_in_last = 1'b0; b_out_rdy = 1'b0;
    tx_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_rdy", 32'(in_rdy), 32'd1);
    chk("rst_out_vld", 32'(out_vld), 32'd0);
    chk("rst_out_dat", out_dat, 32'd0);
    arst_n = 1'b1;
    tick();

    // idle with downstream ready
    out_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_out_vld", 32'(out_vld), 32'd0);
      chk("idle_in_rdy", 32'(in_rdy), 32'd1);
    end
    out_rdy = 1'b0;

    // 1+2+3 and resolve latency
    send(32'd1, 1'b0);
    send(32'd2, 1'b0);
    send(32'd3, 1'b1);
    n = 0;
    while (!out_vld && n < 50) begin
      chk("resolve_in_rdy", 32'(in_rdy), 32'd0);
      tick();
      n++;
    end
    chk("latency", 32'(n), 32'd4);
    recv(32'h0000_0006);

    // cross-chunk carry and wrap
    send(32'h00FF_FFFF, 1'b0);
    send(32'h0000_0001, 1'b1);
    recv(32'h0100_0000);
    send(32'hFFFF_FFFF, 1'b0);
    send(32'h0000_0002, 1'b1);
    recv(32'h0000_0001);

    // backpressure
    send(32'd9, 1'b1);
    n = 0;
    while (!out_vld && n < 50) begin
      tick();
      n++;
    end
    hold = out_dat;
    chk("bp_value", hold, 32'd9);
    for (int i = 0; i < 10; i++) begin
      in_vld  = ((i % 2) == 0);
      in_dat  = $urandom;
      in_last = 1'b1;
      tick();
      chk("bp_out_vld", 32'(out_vld), 32'd1);
      chk("bp_out_dat", out_dat, hold);
      chk("bp_in_rdy", 32'(in_rdy), 32'd0);
    end
    in_vld  = 1'b0;
    in_last = 1'b0;
    recv(32'd9);
    send(32'd5, 1'b1);
    recv(32'h0000_0005);

    // single-beat group, CHUNK=8 and CHUNK=32
    send(32'hDEAD_BEEF, 1'b1);
    recv(32'hDEAD_BEEF);
    chk("b_in_rdy", 32'(b_in_rdy), 32'd1);
    b_in_vld = 1'b1; b_in_dat = 32'hDEAD_BEEF; b_in_last = 1'b1;
    tick();
    b_in_vld = 1'b0; b_in_last = 1'b0;
    chk("b_vld_e0", 32'(b_out_vld), 32'd0);
    tick();
    chk("b_vld_e1", 32'(b_out_vld), 32'd1);
    chk("b_dat", b_out_dat, 32'hDEAD_BEEF);
    b_out_rdy = 1'b1;
    tick();
    b_out_rdy = 1'b0;
    chk("b_vld_after", 32'(b_out_vld), 32'd0);
    chk("b_rdy_after", 32'(b_in_rdy), 32'd1);

    // reset during resolve (chunk 2 pending)
    send(32'd10, 1'b0);
    send(32'd20, 1'b1);
    tick();
    tick();
    arst_n = 1'b0;
    #1;
    chk("midrst_out_vld", 32'(out_vld), 32'd0);
    chk("midrst_in_rdy", 32'(in_rdy), 32'd1);
    chk("midrst_out_dat", out_dat, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    arst_n = 1'b1;
    tick();
    send(32'd7, 1'b1);
    recv(32'h0000_0007);

    // random groups with input gaps and output backpressure
    fork
      begin
        for (int g = 0; g < 30; g++) begin
          int nb;
          nb = int'($urandom_range(1, 64));
          for (int b = 0; b < nb; b++) begin
            repeat ($urandom_range(0, 2)) tick();
            send($urandom, b == nb - 1);
          end
        end
        tx_done = 1'b1;
      end
      begin
        int w = 0;
        while ((!tx_done || sb.size() != 0) && w < 30000) begin
          out_rdy = ($urandom_range(0, 3) != 0);
          tick();
          w++;
        end
        out_rdy = 1'b0;
        if (w >= 30000) chk("rand_timeout", 32'd1, 32'd0);
      end
    join

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
